reg_dump_unit: RTL and testbench
================================

Name: reg_dump_unit

Overview:
- Reader-side companion to the 32x32 register file: on request, halts the core and sweeps a contiguous register range through one register-file read port.
- Streams each (address, value) pair out over a valid/ready interface and accumulates an XOR checksum.
- Sits between the register file's second read port (via a debug mux on the Rs2 select) and the debug/trace host; the core's halt logic honours halt_req.

Parameters:
- DATA_W, 32, register and output data width
- ADDR_W, 5, register index width
- CNT_W, 6, width of word_count (must hold 2**ADDR_W)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a dump; sampled only in IDLE
- start_addr  input  ADDR_W  first register index, latched on accepted start
- end_addr  input  ADDR_W  last register index (inclusive), latched on accepted start
- halt_req  output  1  request core freeze; no register-file writes while high
- halt_ack  input  1  core confirms it is frozen
- rd_addr  output  ADDR_W  register-file read select (drives Rs2 through the debug mux)
- rd_data  input  DATA_W  register-file read data, combinational from rd_addr
- out_valid  output  1  out_addr/out_data hold a word
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high
- out_addr  output  ADDR_W  index of the streamed word
- out_data  output  DATA_W  value of the streamed word
- busy  output  1  high from the cycle after an accepted start until DONE exits
- done  output  1  one-cycle pulse at the end of a dump
- range_err  output  1  sticky until next accepted start; set when start_addr > end_addr
- checksum  output  DATA_W  XOR of all words streamed in the last dump
- word_count  output  CNT_W  number of words streamed in the last dump

Behaviour:
- Reset: rst=1 on any edge sends the FSM to IDLE. All outputs are then 0: halt_req, rd_addr, out_valid, out_addr, out_data, busy, done, range_err, checksum, word_count.
- Reset mid-dump abandons the sweep. halt_req and out_valid drop in the cycle after the reset edge.
- FSM states are IDLE, HALT, READ, SEND, DONE.
- IDLE
  - busy=0, halt_req=0.
  - On start=1: latch start_addr/end_addr, clear checksum, word_count and range_err.
  - If start_addr > end_addr: set range_err and go to DONE; no halt, no words.
  - Otherwise set idx=start_addr and go to HALT.
- HALT
  - halt_req=1, busy=1.
  - Stay until halt_ack=1, then go to READ. No timeout.
- READ (exactly 1 cycle)
  - rd_addr=idx; halt_req stays 1.
  - At the edge: out_data<=rd_data, out_addr<=idx, checksum<=checksum^rd_data, word_count<=word_count+1, out_valid<=1.
  - Go to SEND.
- SEND
  - out_valid=1. out_data and out_addr are held stable while out_ready=0.
  - On handshake: out_valid<=0. If idx==end_addr go to DONE; else idx<=idx+1 and go to READ.
  - idx never wraps: end_addr=31 terminates before the increment.
- DONE (1 cycle)
  - done=1, halt_req<=0, busy<=0 at exit; return to IDLE.
  - checksum and word_count hold until the next accepted start.
- Throughput: one word per 2 cycles with out_ready tied high.
- Latency: with halt_ack already high at the start edge:
  - HALT lasts 1 cycle.
  - First out_valid rises 2 cycles after the start edge.
- start while busy is ignored.
- start in the DONE cycle is ignored; start must be re-asserted in IDLE.
- halt_ack dropping during READ/SEND is ignored. The core's contract is to hold the halt until halt_req falls.
- rd_addr = 0 in all states except READ.
- x0 is read like any other register; it contributes 0 to the checksum.

Test Plan:
- Full sweep: regs x1..x31 preloaded with value=index*0x11111111 (mod 2^32), start_addr=0, end_addr=31, out_ready=1, halt_ack=1 -> 32 words in address order, out_addr 0..31, word_count=32, checksum equals XOR of the 32 values, done pulses once, halt_req low the cycle after done.
- Single register: start_addr=end_addr=5, x5=0xDEADBEEF -> exactly one word (5, 0xDEADBEEF), checksum=0xDEADBEEF, word_count=1.
- Backpressure: range 2..4, out_ready low for 3 cycles on the second word -> out_addr=3 and out_data held stable, no duplicate or lost words, word_count=3.
- Halt wait: halt_ack held low 10 cycles after start -> rd_addr stays 0, out_valid stays 0, halt_req=1 throughout; streaming begins 2 cycles after halt_ack rises.
- Bad range: start_addr=9, end_addr=3 -> range_err=1, done pulses 1 cycle after start, halt_req never asserts, word_count=0, checksum=0.
- Reset mid-dump: rst asserted while in SEND on word 7 of 0..31 -> next cycle all outputs 0 and FSM in IDLE; a following start runs a clean full dump with correct checksum.

Source files
------------

// File: rtl/reg_dump_unit.sv
// Debug register dump: halts the core, sweeps a register range through one
// read port, streams (address, value) pairs and accumulates an XOR checksum.
module reg_dump_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [DATA_W-1:0] checksum,
    output logic [CNT_W-1:0]  word_count
);

    // Output stream: a word transfers on any rising edge where out_valid and
    // out_ready are both high; out_addr/out_data stay stable until then.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last;

    always_comb begin
        state_nx = state;
        halt_req = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        rd_addr  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (start_addr > end_addr) ? S_DONE : S_HALT;
                end
            end
            S_HALT: begin
                halt_req = 1'b1;
                busy     = 1'b1;
                if (halt_ack) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                halt_req = 1'b1;
                busy     = 1'b1;
                rd_addr  = idx;
                state_nx = S_SEND;
            end
            S_SEND: begin
                halt_req = 1'b1;
                busy     = 1'b1;
                if (out_ready) begin
                    state_nx = (idx == last) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                // A rejected range never froze the core, so it must not request it now.
                halt_req = ~range_err;
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            last       <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            checksum   <= '0;
            word_count <= '0;
            range_err  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx        <= start_addr;
                        last       <= end_addr;
                        checksum   <= '0;
                        word_count <= '0;
                        range_err  <= (start_addr > end_addr);
                    end
                end
                S_READ: begin
                    out_data   <= rd_data;
                    out_addr   <= idx;
                    checksum   <= checksum ^ rd_data;
                    word_count <= word_count + CNT_W'(1);
                    out_valid  <= 1'b1;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Stop before incrementing so idx never wraps past the top register.
                        if (idx != last) begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: table-driven dumps against a register-file
// model, plus hand sequences for single register and reset mid-dump.
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  start_addr;
    logic [4:0]  end_addr;
    logic        halt_req;
    logic        halt_ack;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [31:0] checksum;
    logic [5:0]  word_count;

    logic [31:0] regs [32];
    logic [36:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [4:0] sa;
        logic [4:0] ea;
        int         stall_idx;
        int         stall_n;
        int         halt_wait;
        int         exp_count;
        logic       exp_err;
    } vec_t;

    vec_t vecs [6];

    assign rd_data = regs[rd_addr];

    reg_dump_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .halt_req   (halt_req),
        .halt_ack   (halt_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .range_err  (range_err),
        .checksum   (checksum),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_halt_req"}, 32'(halt_req), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_addr"}, 32'(out_addr), 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_range_err"}, 32'(range_err), 0);
        check({tag, "_checksum"}, checksum, 0);
        check({tag, "_word_count"}, 32'(word_count), 0);
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic run_dump(input logic [4:0] sa, input logic [4:0] ea, input int stall_idx,
                            input int stall_n, input int halt_wait, input int exp_count,
                            input logic exp_err);
        logic [31:0] exp_cs;
        logic [36:0] w;
        int          got_n;
        int          cyc;
        int          stall_left;
        int          h;
        int          exp_done;
        int          first_valid;
        bit          seen_done;
        bit          halt_seen;
        exp_cs      = '0;
        got_n       = 0;
        cyc         = 0;
        stall_left  = stall_n;
        first_valid = -1;
        seen_done   = 1'b0;
        halt_seen   = 1'b0;
        h           = (halt_wait > 0) ? halt_wait : 1;
        exp_done    = exp_err ? 1 : 2 * exp_count + 1 + h + stall_n;
        exp_q.delete();
        if (!exp_err) begin
            for (int a = int'(sa); a <= int'(ea); a++) begin
                exp_q.push_back({5'(a), regs[a]});
                exp_cs ^= regs[a];
            end
        end
        @(negedge clk);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        halt_ack   = (halt_wait == 0);
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < 300) begin
            cyc++;
            if (halt_req) halt_seen = 1'b1;
            if (cyc <= halt_wait) begin
                check("hold_rd_addr", 32'(rd_addr), 0);
                check("hold_out_valid", 32'(out_valid), 0);
                check("hold_halt_req", 32'(halt_req), 1);
                if (cyc == halt_wait) halt_ack = 1'b1;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid) begin
                check("rd_addr_in_send", 32'(rd_addr), 0);
                if (got_n == stall_idx && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    if (exp_q.size() > 0) begin
                        w = exp_q[0];
                        check("stall_out_addr", 32'(out_addr), 32'(w[36:32]));
                        check("stall_out_data", out_data, w[31:0]);
                    end
                end else begin
                    out_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("extra_word", 32'(out_addr), 32'hffff_ffff);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_addr", 32'(out_addr), 32'(w[36:32]));
                        check("word_data", out_data, w[31:0]);
                    end
                    got_n++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_cycle", 32'(cyc), 32'(exp_done));
                check("word_count", 32'(word_count), 32'(exp_count));
                check("checksum", checksum, exp_cs);
                check("range_err", 32'(range_err), 32'(exp_err));
                check("words_missing", 32'(exp_q.size()), 0);
                check("words_streamed", 32'(got_n), 32'(exp_count));
            end
            @(negedge clk);
        end
        if (!seen_done) check("done_timeout", 0, 1);
        check("post_done", 32'(done), 0);
        check("post_halt_req", 32'(halt_req), 0);
        check("post_busy", 32'(busy), 0);
        check("halt_asserted", 32'(halt_seen), 32'(!exp_err));
        if (!exp_err) check("first_valid_cycle", 32'(first_valid), 32'(h + 2));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        halt_ack   = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;

        //            sa     ea     stall  n  hwait count err
        vecs[0] = '{5'd0,  5'd31, -1,    0, 0,    32,   1'b0};
        vecs[1] = '{5'd2,  5'd4,  1,     3, 0,    3,    1'b0};
        vecs[2] = '{5'd9,  5'd3,  -1,    0, 0,    0,    1'b1};
        vecs[3] = '{5'd0,  5'd0,  -1,    0, 0,    1,    1'b0};
        vecs[4] = '{5'd10, 5'd20, -1,    0, 10,   11,   1'b0};
        vecs[5] = '{5'd30, 5'd31, 0,     2, 0,    2,    1'b0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_dump(vecs[v].sa, vecs[v].ea, vecs[v].stall_idx, vecs[v].stall_n,
                     vecs[v].halt_wait, vecs[v].exp_count, vecs[v].exp_err);
        end

        // Single register with a hand-known value.
        regs[5] = 32'hDEAD_BEEF;
        run_dump(5'd5, 5'd5, -1, 0, 0, 1, 1'b0);
        check("single_checksum", checksum, 32'hDEAD_BEEF);
        check("single_word_count", 32'(word_count), 1);
        regs[5] = 32'h5555_5555;

        // Reset while word 7 of a full sweep sits in SEND.
        begin
            int  cyc;
            bit  found;
            cyc   = 0;
            found = 1'b0;
            @(negedge clk);
            start_addr = 5'd0;
            end_addr   = 5'd31;
            start      = 1'b1;
            halt_ack   = 1'b1;
            out_ready  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (!found && cyc < 100) begin
                cyc++;
                if (out_valid && out_addr == 5'd7) found = 1'b1;
                else @(negedge clk);
            end
            check("reach_word7", 32'(found), 1);
            out_ready = 1'b0;
            rst       = 1'b1;
            @(negedge clk);
            check_all_zero("midreset");
            rst       = 1'b0;
            out_ready = 1'b1;
        end
        run_dump(5'd0, 5'd31, -1, 0, 0, 32, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
